// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
//==============================================================================
// Package  : hazard_scoreboard_pkg
// Desc     : Shared types and constants for the issue-side hazard scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W = 5;

  // One in-flight instruction: destination, whether it really writes a
  // register (rd_en and rd != x0), and whether its result is not yet on bypass.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 wr;
    logic                 late;
  } sb_entry_t;

  // Width able to hold 0..depth inclusive (occupancy, flush count).
  function automatic int sb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_match.sv
`default_nettype none
//==============================================================================
// Module   : sb_match
// Desc     : Youngest-producer lookup for one source operand. Reports blocked
//            when the youngest valid writer of the source is still late.
// Revision : 1.0 - initial release
//==============================================================================
module sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = sb_cnt_w(DEPTH)
) (
  input  sb_entry_t            i_entries [DEPTH],
  input  logic [PTR_W-1:0]     i_head,
  input  logic [CNT_W-1:0]     i_occ,
  input  logic                 i_src_en,
  input  logic [REG_IDX_W-1:0] i_src,
  output logic                 o_blocked
);

  logic w_late_hit;

  // Walk oldest to youngest; the last match overwrites, so the youngest wins.
  always_comb begin
    w_late_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < i_occ) &&
          i_entries[i_head + PTR_W'(k)].wr &&
          (i_entries[i_head + PTR_W'(k)].rd == i_src)) begin
        w_late_hit = i_entries[i_head + PTR_W'(k)].late;
      end
    end
  end

  // x0 is hard-wired and never creates a dependency.
  assign o_blocked = i_src_en && (i_src != '0) && w_late_hit;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
//==============================================================================
// Module   : hazard_scoreboard
// Desc     : In-order FIFO of in-flight destinations between ID and EXE.
//            Grants issue_ok when no enabled source depends on a late result.
// Options  : HAZARD_SB_STATS_EN adds stall_cycles / full_cycles counters.
// Revision : 1.0 - initial release
//==============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = sb_cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic                 id_rs1_en,
  input  logic                 id_rs2_en,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rd_en,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_late,
  input  logic                 exe_ready,
  output logic                 issue_ok,
  input  logic                 res_valid,
  input  logic [REG_IDX_W-1:0] res_rd,
  input  logic                 wb_retire,
  input  logic [CNT_W-1:0]     flush_n,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 err
`ifdef HAZARD_SB_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          full_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t        r_entries     [DEPTH];
  sb_entry_t        w_entries_nxt [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [CNT_W-1:0] r_occ, w_occ_ret, w_flush_amt, w_occ_nxt;
  logic             r_err, w_err_nxt;
  logic             w_pop, w_res_hit, w_fire, w_wr, w_blk1, w_blk2;

  sb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_match_rs1 (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_occ     (r_occ),
    .i_src_en  (id_rs1_en),
    .i_src     (id_rs1),
    .o_blocked (w_blk1)
  );

  sb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_match_rs2 (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_occ     (r_occ),
    .i_src_en  (id_rs2_en),
    .i_src     (id_rs2),
    .o_blocked (w_blk2)
  );

  assign full      = (r_occ == CNT_W'(DEPTH));
  assign empty     = (r_occ == '0);
  assign occupancy = r_occ;
  assign err       = r_err;
  // Full is the pre-edge value, so a same-cycle retire never frees a slot for issue.
  assign issue_ok  = !rst && id_valid && !w_blk1 && !w_blk2 && !full && (flush_n == '0);
  assign w_fire    = issue_ok && exe_ready;
  assign w_wr      = id_rd_en && (id_rd != '0);

  // Next state applied in order: retire pop, late clear, flush rewind, issue push.
  always_comb begin
    w_entries_nxt = r_entries;
    w_err_nxt     = r_err;
    w_pop         = 1'b0;
    w_res_hit     = 1'b0;

    if (wb_retire) begin
      if (r_occ == '0) begin
        w_err_nxt = 1'b1;
      end else begin
        w_pop = 1'b1;
        if (r_entries[r_head].late) w_err_nxt = 1'b1;
        w_entries_nxt[r_head] = '0;
      end
    end
    w_occ_ret  = r_occ - CNT_W'(w_pop);
    w_head_nxt = r_head + PTR_W'(w_pop);

    // Oldest matching late producer is the one whose result just appeared.
    if (res_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!w_res_hit && (CNT_W'(k) < w_occ_ret) &&
            r_entries[w_head_nxt + PTR_W'(k)].late &&
            (r_entries[w_head_nxt + PTR_W'(k)].rd == res_rd)) begin
          w_entries_nxt[w_head_nxt + PTR_W'(k)].late = 1'b0;
          w_res_hit = 1'b1;
        end
      end
      if (!w_res_hit) w_err_nxt = 1'b1;
    end

    if (flush_n > w_occ_ret) begin
      w_flush_amt = w_occ_ret;
      w_err_nxt   = 1'b1;
    end else begin
      w_flush_amt = flush_n;
    end
    w_tail_nxt = r_tail - PTR_W'(w_flush_amt);

    // Every issued instruction takes a slot, even if it writes nothing.
    if (w_fire) begin
      w_entries_nxt[w_tail_nxt] = '{rd: id_rd, wr: w_wr, late: id_late && w_wr};
      w_tail_nxt = w_tail_nxt + PTR_W'(1);
    end
    w_occ_nxt = w_occ_ret - w_flush_amt + CNT_W'(w_fire);
  end

  // Scoreboard state register; reset discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_entries <= w_entries_nxt;
      r_head    <= w_head_nxt;
      r_tail    <= w_tail_nxt;
      r_occ     <= w_occ_nxt;
      r_err     <= w_err_nxt;
    end
  end

`ifdef HAZARD_SB_STATS_EN
  logic [31:0] r_stall_cycles, r_full_cycles;

  // Saturating counters: pure RAW stalls and cycles lost to a full scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_full_cycles  <= '0;
    end else begin
      if (id_valid && !issue_ok && (flush_n == '0) && !full && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (id_valid && full && (r_full_cycles != '1))
        r_full_cycles <= r_full_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign full_cycles  = r_full_cycles;
`endif

endmodule
`default_nettype wire
